inst_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the 16-bit, 1024-word instruction memory and downstream into decode. It owns the 10-bit program counter, drives the memory address, and captures the combinationally returned instruction into a 2-entry prefetch queue. Decode consumes the queue through a valid/ready handshake. Execute can redirect the PC for jumps and branches, which flushes the queue.

---
 rtl/inst_fetch_unit_if.sv | 20 ++
 rtl/inst_fetch_unit.sv | 102 ++++++++++
 tb/tb_inst_fetch_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory address/data plus the decode valid/ready handshake.
// master = fetch unit, slave = memory/decode side.
interface inst_fetch_unit_if;
   logic [9:0]  imem_addr;
   logic [15:0] imem_inst;
   logic [15:0] ir;
   logic [9:0]  ir_pc;
   logic        ir_valid;
   logic        ir_ready;

   modport master (
      output imem_addr, ir, ir_pc, ir_valid,
      input  imem_inst, ir_ready
   );

   modport slave (
      input  imem_addr, ir, ir_pc, ir_valid,
      output imem_inst, ir_ready
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, fetches into a 2-entry prefetch queue feeding decode.
// Optional push counter output fetch_count is enabled by defining FETCH_PERF_EN.
module inst_fetch_unit #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  halt,
   input  logic                  redirect,
   input  logic [9:0]            redirect_pc,
`ifdef FETCH_PERF_EN
   output logic [15:0]           fetch_count,
`endif
   inst_fetch_unit_if.master     bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [9:0]  pc;
   logic [1:0]  count;
   logic [9:0]  q_pc   [2];
   logic [15:0] q_inst [2];
   logic        push, pop;

   assign bus.imem_addr = pc;
   assign bus.ir        = q_inst[0];
   assign bus.ir_pc     = q_pc[0];
   assign bus.ir_valid  = (count != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (halt)  state_nxt = HALTED;
         HALTED:  if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
      pop  = bus.ir_valid && bus.ir_ready;
      push = (state == RUN) && !redirect && ((count < 2'(DEPTH)) || pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc    <= '0;
         count <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            q_pc[i]   <= '0;
            q_inst[i] <= '0;
         end
      end else if (redirect) begin
         // a pop in this cycle is squashed along with the rest of the queue
         pc    <= redirect_pc;
         count <= '0;
      end else begin
         if (push) pc <= pc + 10'd1;
         case ({push, pop})
            2'b10: begin
               q_pc[count[0]]   <= pc;
               q_inst[count[0]] <= bus.imem_inst;
               count            <= count + 2'd1;
            end
            2'b01: begin
               q_pc[0]   <= q_pc[1];
               q_inst[0] <= q_inst[1];
               count     <= count - 2'd1;
            end
            2'b11: begin
               // with one entry the incoming word becomes the new head directly
               if (count == 2'd1) begin
                  q_pc[0]   <= pc;
                  q_inst[0] <= bus.imem_inst;
               end else begin
                  q_pc[0]   <= q_pc[1];
                  q_inst[0] <= q_inst[1];
                  q_pc[1]   <= pc;
                  q_inst[1] <= bus.imem_inst;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n)                        fetch_count <= '0;
      else if (push && fetch_count != '1) fetch_count <= fetch_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus queues expected {pc,inst} transfers,
// a negedge monitor pops and compares each completed decode transfer.
module tb_inst_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, halt, redirect;
   logic [9:0] redirect_pc;
`ifdef FETCH_PERF_EN
   logic [15:0] fetch_count;
`endif

   inst_fetch_unit_if bus ();

   logic [15:0] mem [1024];
   assign bus.imem_inst = mem[bus.imem_addr];

   int checks   = 0;
   int failures = 0;
   logic [25:0] expq [$];

   always #5 clk = ~clk;

   inst_fetch_unit #(.DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .halt        (halt),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
`ifdef FETCH_PERF_EN
      .fetch_count (fetch_count),
`endif
      .bus         (bus.master)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic exp_push(input int unsigned p);
      logic [9:0] a;
      a = 10'(p);
      expq.push_back({a, mem[a]});
   endtask

   // Transfer completes at the next rising edge; a redirect in that cycle squashes it.
   always @(negedge clk) begin
      if (rst_n && bus.ir_valid && bus.ir_ready && !redirect) begin
         checks++;
         if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_transfer got pc=%0d inst=%h", bus.ir_pc, bus.ir);
         end else begin
            logic [25:0] e;
            e = expq.pop_front();
            if ({bus.ir_pc, bus.ir} !== e) begin
               failures++;
               $display("FAIL transfer got pc=%0d inst=%h exp pc=%0d inst=%h",
                        bus.ir_pc, bus.ir, e[25:16], e[15:0]);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h5A00 ^ 16'(i * 7);
      mem[0]  = 16'hE500;
      mem[1]  = 16'h01F4;
      mem[2]  = 16'h8802;
      mem[21] = 16'h11FE;

      rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
      bus.ir_ready = 1'b0;
      step(); step();
      check("rst_imem_addr", 32'(bus.imem_addr), 0);
      check("rst_ir_valid",  32'(bus.ir_valid),  0);
      check("rst_ir",        32'(bus.ir),        0);
      check("rst_ir_pc",     32'(bus.ir_pc),     0);
`ifdef FETCH_PERF_EN
      check("rst_fetch_count", 32'(fetch_count), 0);
`endif
      rst_n = 1'b1;
      step();
      check("idle_no_fetch", 32'(bus.ir_valid), 0);

      // streaming fetch with decode always ready
      bus.ir_ready = 1'b1;
      exp_push(0); exp_push(1); exp_push(2);
      start = 1'b1; step(); start = 1'b0;
      check("s1_latency_invalid", 32'(bus.ir_valid), 0);
      step();
      check("s1_first_valid", 32'(bus.ir_valid), 1);
      check("s1_first_ir",    32'(bus.ir),       32'h0000E500);
      step();
      halt = 1'b1; step(); halt = 1'b0;
`ifdef FETCH_PERF_EN
      check("s1_fetch_count", 32'(fetch_count), 3);
`endif
      step(); step();
      check("s1_drained",   32'(bus.ir_valid),  0);
      check("s1_pc_frozen", 32'(bus.imem_addr), 3);

      // backpressure fills the queue, then release
      bus.ir_ready = 1'b0;
      rst_n = 1'b0; step(); rst_n = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      step(); step(); step();
      check("s2_full_addr",  32'(bus.imem_addr), 2);
      check("s2_full_ir",    32'(bus.ir),        32'h0000E500);
      check("s2_full_ir_pc", 32'(bus.ir_pc),     0);
      check("s2_full_valid", 32'(bus.ir_valid),  1);
      exp_push(0); exp_push(1); exp_push(2); exp_push(3);
      bus.ir_ready = 1'b1;
      step();
      halt = 1'b1; step(); halt = 1'b0;
      step(); step();
      check("s2_drained", 32'(bus.ir_valid),  0);
      check("s2_addr",    32'(bus.imem_addr), 4);

      // redirect with full queue (and a squashed pop in the redirect cycle)
      bus.ir_ready = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      step(); step(); step();
      check("s3_full_addr", 32'(bus.imem_addr), 6);
      redirect = 1'b1; redirect_pc = 10'd21; bus.ir_ready = 1'b1;
      step();
      redirect = 1'b0; bus.ir_ready = 1'b0;
      check("s3_flush_valid", 32'(bus.ir_valid),  0);
      check("s3_redir_addr",  32'(bus.imem_addr), 21);
      step();
      check("s3_target_valid", 32'(bus.ir_valid), 1);
      check("s3_target_ir",    32'(bus.ir),       32'h000011FE);
      check("s3_target_ir_pc", 32'(bus.ir_pc),    21);
      step();
      exp_push(21); exp_push(22); exp_push(23); exp_push(24);
      bus.ir_ready = 1'b1;
      step();
      halt = 1'b1; step(); halt = 1'b0;
      step(); step();
      check("s3_drained", 32'(bus.ir_valid),  0);
      check("s3_addr",    32'(bus.imem_addr), 25);

      // redirect while halted only moves the PC; then wrap at 1023
      bus.ir_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 10'd1023; step(); redirect = 1'b0;
      check("s4_halted_redir_addr",  32'(bus.imem_addr), 1023);
      check("s4_halted_redir_valid", 32'(bus.ir_valid),  0);
      exp_push(1023); exp_push(0); exp_push(1);
      bus.ir_ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      step();
      check("s4_wrap_addr", 32'(bus.imem_addr), 0);
      step();
      halt = 1'b1; step(); halt = 1'b0;
      step(); step();
      check("s4_drained", 32'(bus.ir_valid),  0);
      check("s4_addr",    32'(bus.imem_addr), 2);

      // halt at pc 5 with decode stalled, drain, resume from frozen pc
      bus.ir_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 10'd5; step(); redirect = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      halt = 1'b1; step(); halt = 1'b0;
      step(); step();
      check("s5_frozen_addr", 32'(bus.imem_addr), 6);
      check("s5_held_valid",  32'(bus.ir_valid),  1);
      check("s5_held_ir_pc",  32'(bus.ir_pc),     5);
      exp_push(5);
      bus.ir_ready = 1'b1;
      step(); step();
      check("s5_drained",     32'(bus.ir_valid),  0);
      check("s5_still_addr",  32'(bus.imem_addr), 6);
      exp_push(6); exp_push(7);
      start = 1'b1; step(); start = 1'b0;
      step();
      halt = 1'b1; step(); halt = 1'b0;
      step(); step();
      check("s5_resume_drained", 32'(bus.ir_valid),  0);
      check("s5_resume_addr",    32'(bus.imem_addr), 8);

      // reset while running with a full queue
      bus.ir_ready = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      step(); step(); step();
      check("s6_full_valid", 32'(bus.ir_valid), 1);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      check("s6_rst_valid", 32'(bus.ir_valid),  0);
      check("s6_rst_addr",  32'(bus.imem_addr), 0);
`ifdef FETCH_PERF_EN
      check("s6_rst_fetch_count", 32'(fetch_count), 0);
`endif
      step(); step(); step();
      check("s6_idle_valid", 32'(bus.ir_valid),  0);
      check("s6_idle_addr",  32'(bus.imem_addr), 0);
      exp_push(0); exp_push(1);
      bus.ir_ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      step();
      halt = 1'b1; step(); halt = 1'b0;
      step(); step();
      check("s6_drained", 32'(bus.ir_valid),  0);
      check("s6_addr",    32'(bus.imem_addr), 2);

      for (int i = 0; i < 50 && expq.size() != 0; i++) step();
      check("scoreboard_empty", 32'(expq.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
